// File: rtl/verifier_sequencer_pkg.sv
// verifier_sequencer_pkg: shared state encoding and LED decode for the verifier sequencer
package verifier_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PASS   = 3'd1,
        FAIL   = 3'd2,
        LOCKED = 3'd3,
        WON    = 3'd4
    } state_e;

    // Returns {red, green}; the two LEDs are never lit together.
    function automatic logic [1:0] led_pair(state_e s, logic blink_on);
        return (s == PASS || s == WON) ? 2'b01 :
               (s == LOCKED)           ? 2'b10 :
               (s == FAIL)             ? {blink_on, 1'b0} : 2'b00;
    endfunction

endpackage

// File: rtl/verifier_sequencer_if.sv
// verifier_sequencer_if: strobe/flag inputs and LED/status outputs of the sequencer
//   master: drives check_valid, verifier, restart; observes LEDs and status
//   slave : the sequencer side
interface verifier_sequencer_if #(
    parameter int LEVEL_W = 2,
    parameter int ATT_W   = 2
);
    logic               check_valid;
    logic               verifier;
    logic               restart;
    logic               ledr_out;
    logic               ledg_out;
    logic [LEVEL_W-1:0] level;
    logic [ATT_W-1:0]   attempts_left;
    logic               level_up;
    logic               game_won;
    logic               locked;
    logic               busy;

    modport master (
        output check_valid, verifier, restart,
        input  ledr_out, ledg_out, level, attempts_left, level_up, game_won, locked, busy
    );

    modport slave (
        input  check_valid, verifier, restart,
        output ledr_out, ledg_out, level, attempts_left, level_up, game_won, locked, busy
    );
endinterface

// File: rtl/verifier_sequencer_phase_timer.sv
// verifier_sequencer_phase_timer: CNT_W-bit up-counter that flags the last cycle of a phase
//   clear: restart at 0 (wins over en); en: count; limit: phase length; done: count == limit-1
//   The counter wraps to 0 on done so back-to-back phases need no extra clear.
module verifier_sequencer_phase_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        done  = en && (cnt_q == limit - 1'b1);
        cnt_d = clear ? '0 : en ? (done ? '0 : cnt_q + 1'b1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/verifier_sequencer.sv
// verifier_sequencer: samples the verifier flag, drives timed LED patterns, tracks level/attempts
//   clk, rst: clock and synchronous active-high reset
//   bus     : check_valid/verifier/restart in; LEDs, level, attempts_left, level_up,
//             game_won, locked, busy out
module verifier_sequencer
    import verifier_sequencer_pkg::*;
#(
    parameter int NUM_LEVELS   = 4,
    parameter int LEVEL_W      = 2,
    parameter int MAX_ATTEMPTS = 3,
    parameter int ATT_W        = 2,
    parameter int HOLD_CYCLES  = 25000000,
    parameter int BLINK_HALF   = 12500000,
    parameter int BLINK_COUNT  = 3,
    parameter int CNT_W        = 26
) (
    input  logic                   clk,
    input  logic                   rst,
    verifier_sequencer_if.slave    bus
);
    // blink_q counts half-phases: even = red on, odd = red off
    localparam int BW = $clog2(2 * BLINK_COUNT);
    localparam logic [BW-1:0]      BLINK_LAST = BW'(2 * BLINK_COUNT - 1);
    localparam logic [CNT_W-1:0]   HOLD_L     = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]   HALF_L     = CNT_W'(BLINK_HALF);
    localparam logic [LEVEL_W-1:0] LAST_LVL   = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [ATT_W-1:0]   ATT_MAX    = ATT_W'(MAX_ATTEMPTS);

    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [ATT_W-1:0]   att_q, att_d;
    logic [BW-1:0]      blink_q, blink_d;
    logic               level_up_q, level_up_d;
    logic               timer_done;

    // Any state change restarts the shared timer, so every phase begins at 0.
    verifier_sequencer_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state_d != state_q),
        .en    (state_q == PASS || state_q == FAIL),
        .limit (state_q == PASS ? HOLD_L : HALF_L),
        .done  (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        att_d      = att_q;
        blink_d    = blink_q;
        level_up_d = 1'b0;
        if (bus.restart) begin
            state_d = IDLE;
            level_d = '0;
            att_d   = ATT_MAX;
            blink_d = '0;
        end else begin
            case (state_q)
                IDLE: if (bus.check_valid) begin
                    state_d = bus.verifier ? PASS : FAIL;
                    att_d   = bus.verifier ? att_q : att_q - 1'b1;
                    blink_d = '0;
                end
                PASS: if (timer_done) begin
                    state_d    = (level_q == LAST_LVL) ? WON : IDLE;
                    level_d    = (level_q == LAST_LVL) ? level_q : level_q + 1'b1;
                    att_d      = (level_q == LAST_LVL) ? att_q : ATT_MAX;
                    level_up_d = (level_q != LAST_LVL);
                end
                FAIL: if (timer_done) begin
                    blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + 1'b1;
                    state_d = (blink_q != BLINK_LAST) ? FAIL : (att_q == '0) ? LOCKED : IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            level_q    <= '0;
            att_q      <= ATT_MAX;
            blink_q    <= '0;
            level_up_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            att_q      <= att_d;
            blink_q    <= blink_d;
            level_up_q <= level_up_d;
        end
    end

    assign {bus.ledr_out, bus.ledg_out} = led_pair(state_q, ~blink_q[0]);
    assign bus.level         = level_q;
    assign bus.attempts_left = att_q;
    assign bus.level_up      = level_up_q;
    assign bus.game_won      = (state_q == WON);
    assign bus.locked        = (state_q == LOCKED);
    assign bus.busy          = (state_q != IDLE);
endmodule

// File: doc/verifier_sequencer.md
Name: verifier_sequencer

Overview:
Parametrised multi-level successor to the single-level LED verifier. It samples the verifier flag on a strobe and drives the red/green LEDs with timed patterns: green hold on a pass, red blink on a fail. It tracks the game level and the remaining attempts, and enters a lockout when attempts run out. It sits between the per-level compare logic and the board LEDs, and feeds level and status back to the level-select logic.

Parameters:
NUM_LEVELS, 4, number of game levels; the last level index is NUM_LEVELS-1
LEVEL_W, 2, width of level; must satisfy 2^LEVEL_W >= NUM_LEVELS
MAX_ATTEMPTS, 3, failed checks allowed per level before lockout (>=1)
ATT_W, 2, width of attempts_left; must hold MAX_ATTEMPTS
HOLD_CYCLES, 25000000, length of the green hold after a pass, in cycles (>=1)
BLINK_HALF, 12500000, length of each red on-phase and each off-phase, in cycles (>=1)
BLINK_COUNT, 3, number of red on/off pairs per fail (>=1)
CNT_W, 26, width of the phase timer; must hold max(HOLD_CYCLES, BLINK_HALF)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
check_valid  input  1  one-cycle strobe: sample verifier now
verifier  input  1  1 = player answer matches, 0 = mismatch
restart  input  1  synchronous game restart, allowed in any state
ledr_out  output  1  red LED
ledg_out  output  1  green LED
level  output  LEVEL_W  current level index
attempts_left  output  ATT_W  fails still allowed on the current level
level_up  output  1  one-cycle pulse when the level advances
game_won  output  1  high in WON
locked  output  1  high in LOCKED
busy  output  1  high in any state other than IDLE; check_valid is ignored while high

Behaviour:
- States: IDLE, PASS, FAIL, LOCKED, WON. State, level, attempts, timer and blink counter are all registered. LED and status outputs decode from the registered state; the only exception is level_up, which is a registered pulse.
- Reset (rst=1 at a clk edge):
  - state=IDLE, level=0, attempts_left=MAX_ATTEMPTS, timer=0.
  - All 1-bit outputs are 0.
  - rst has priority over everything, including mid-blink and mid-hold.
- restart=1 at an edge (rst=0): same effect as reset, from any state. restart beats a simultaneous check_valid.
- IDLE:
  - Both LEDs off.
  - check_valid=1 at an edge: verifier=1 goes to PASS; verifier=0 goes to FAIL and decrements attempts_left in the same edge.
  - LED latency: the pattern appears in the cycle after the sampling edge.
- PASS:
  - ledg_out=1, ledr_out=0, for exactly HOLD_CYCLES cycles.
  - At expiry, if level==NUM_LEVELS-1: go to WON.
  - Otherwise at expiry: level+1, attempts_left reloads to MAX_ATTEMPTS, level_up=1 for one cycle (the first IDLE cycle), then IDLE.
- FAIL:
  - ledg_out=0. ledr_out is 1 for BLINK_HALF cycles, then 0 for BLINK_HALF cycles, repeated BLINK_COUNT times.
  - Total duration is 2*BLINK_HALF*BLINK_COUNT cycles.
  - At expiry: if attempts_left==0, go to LOCKED; otherwise go to IDLE. The level is unchanged.
- LOCKED: ledr_out=1 steady, locked=1. Only rst or restart exits.
- WON: ledg_out=1 steady, game_won=1. Only rst or restart exits.
- The LEDs are never both on.
- attempts_left never wraps below 0: a fail is only reachable with attempts_left>=1.
- level never exceeds NUM_LEVELS-1.
- Timer: loads 0 on state entry and counts up. Expiry is timer==limit-1.

Decomposition:
- Shared package holds:
  - the state encoding localparams (IDLE=3'd0, PASS=3'd1, FAIL=3'd2, LOCKED=3'd3, WON=3'd4);
  - a function returning the LED pair for a given state and blink phase.
- One natural sub-module, phase_timer: a CNT_W-bit up-counter with clear, en and a LIMIT input, and a done output. It is instantiated once and shared by PASS and FAIL. The blink pair counter stays in the top level.

Test Plan:
Overrides for all scenarios: HOLD_CYCLES=4, BLINK_HALF=2, BLINK_COUNT=2, MAX_ATTEMPTS=2, NUM_LEVELS=2.
1. Reset: hold rst for 2 cycles -> level=0, attempts_left=2, ledr_out=ledg_out=0, busy=0.
2. Pass then advance: pulse check_valid with verifier=1 -> ledg_out=1 for exactly 4 cycles; then level=1, level_up is high for one cycle, attempts_left=2.
3. Fail blink: pulse check_valid with verifier=0 -> attempts_left=1 on the next cycle; ledr_out pattern is 1,1,0,0,1,1,0,0; then IDLE with level unchanged.
4. Lockout: two fails -> after the second blink, locked=1 and ledr_out=1 steady; check_valid pulses are ignored; restart -> IDLE, level=0, attempts_left=2.
5. Win: pass level 0, then pass level 1 -> game_won=1 and ledg_out=1 steady; there is no level_up pulse on the final level.
6. Mid-operation events: rst asserted during the 2nd cycle of FAIL -> next cycle both LEDs 0, attempts_left=2. check_valid together with restart in IDLE -> stays IDLE. check_valid pulsed during PASS -> ignored.
